pixel_writer: RTL
=================

Name: pixel_writer

Overview:
- Upstream stage of the SRAM frame buffer: accepts the incoming JPEG byte stream one byte at a time, packs byte pairs into 16-bit words, and writes them sequentially to SRAM from address 0.
- Detects the FF,D9 end-of-image marker, flushes any partial word, and raises frame_done.
- The downstream pixel reader consumes the buffer, so packing is low byte first: byte 2n goes to word n [7:0], byte 2n+1 goes to word n [15:8].

Parameters:
- ADDR_W, 16, SRAM word-address width.
- MAX_ADDR, 16'hFFFF, last writable word address.
- PAD_BYTE, 8'h00, fill value for [15:8] when a frame ends on an odd byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; held by the buffer controller when the block is unused
- in_data  in  8  incoming byte
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  byte accepted on a cycle where in_valid && in_ready
- sram_ready  in  1  SRAM operation complete (level)
- sram_addr  out  ADDR_W  write word address
- sram_wdata  out  16  write data
- sram_rw  out  1  constant 0 (write)
- sram_start  out  1  active-low start pulse
- word_count  out  ADDR_W+1  number of words written this frame
- frame_done  out  1  sticky; end marker written
- overflow  out  1  sticky; write attempted past MAX_ADDR

Behaviour:
- Reset (synchronous, active-high, takes priority over everything) forces: state S_LOW, sram_addr 0, sram_wdata 0, sram_start 1, in_ready 0 (rises the cycle after reset deasserts), word_count 0, frame_done 0, overflow 0, prev_byte 0. Reset during an SRAM write abandons it; the block does not wait for sram_ready.
- S_LOW:
  - in_ready=1.
  - On accept: in_data goes to wdata[7:0] and prev_byte is updated.
  - If prev_byte==FF and in_data==D9: set wdata[15:8]=PAD_BYTE and go to S_WRITE with end_flag=1.
  - Otherwise go to S_HIGH.
- S_HIGH:
  - in_ready=1.
  - On accept: in_data goes to wdata[15:8]; end_flag = (prev_byte==FF && in_data==D9); go to S_WRITE.
- Marker detection spans word boundaries: prev_byte carries over from the previous word.
- S_WRITE (1 cycle):
  - in_ready=0.
  - If sram_addr > MAX_ADDR (the counter has passed the end): set overflow=1, do not pulse, go to S_DONE.
  - Otherwise: sram_start=0 for exactly this cycle, with sram_addr and sram_wdata stable; go to S_WAIT.
- S_WAIT:
  - in_ready=0, sram_start=1. sram_ready is sampled only from the cycle after the pulse.
  - On sram_ready=1: word_count+=1 and sram_addr+=1.
  - Next state is S_DONE if end_flag, otherwise S_LOW.
  - sram_addr is ADDR_W+1 bits internally, so it may reach MAX_ADDR+1 without wrapping; the output is truncated to ADDR_W.
- S_DONE:
  - in_ready=0, frame_done=1. Holds until reset.
  - Further in_valid is ignored, and no byte is lost silently: upstream sees in_ready=0.
- sram_addr and sram_wdata hold their values until the next S_WRITE.
- Throughput: 2 accepted bytes per word, plus 1 cycle in S_WRITE, plus the SRAM latency in S_WAIT.
- in_valid while in_ready=0 is not accepted. The upstream source must hold in_data and in_valid until the handshake completes.
- A FF byte followed by a non-D9 byte is ordinary data.
- FF,FF,D9 ends the frame on the D9.

Test Plan:
- Stream 11,22,33,44 with an SRAM model responding with a 3-cycle ready delay → writes 2211@0 then 4433@1; one sram_start low pulse per word; word_count=2; frame_done=0.
- Stream 01,FF,D9 → writes FF01@0, then 00D9@1 (padded); frame_done=1; in_ready stays 0 afterwards.
- Stream AA,FF,D9,BB → FF AA... i.e. FFAA@0 then D9 in the low byte triggers the end: 00D9@1; BB is never accepted; word_count=2.
- Stream FF,12,FF,FF,D9 → 12FF@0, FFFF@1, 00D9@2; frame_done asserts only after the D9 write completes.
- MAX_ADDR=1, stream 6 non-marker bytes → words 0 and 1 written; third word sets overflow=1, no sram_start pulse; state S_DONE.
- Assert reset for 1 cycle while in S_WAIT → all outputs return to reset values on the next edge; a following stream writes from address 0 again.

Source files
------------

// File: rtl/pixel_writer_if.sv
// rtl/pixel_writer_if.sv - byte stream in and SRAM write bus out of the pixel writer
interface pixel_writer_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sram_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wdata;
    logic              sram_rw;
    logic              sram_start;

    // master: the writer itself (drives the SRAM bus, back-pressures the stream)
    modport master (
        input  in_data, in_valid, sram_ready,
        output in_ready, sram_addr, sram_wdata, sram_rw, sram_start
    );

    // slave: byte source plus SRAM device
    modport slave (
        output in_data, in_valid, sram_ready,
        input  in_ready, sram_addr, sram_wdata, sram_rw, sram_start
    );
endinterface

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - packs JPEG bytes into 16-bit words and writes them to SRAM until FF,D9
module pixel_writer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 16'hFFFF,
    parameter logic [7:0]        PAD_BYTE = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    pixel_writer_if.master  bus,
    output logic [ADDR_W:0] word_count,
    output logic            frame_done,
    output logic            overflow
);
    typedef enum logic [2:0] {
        S_LOW,
        S_HIGH,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [7:0]      prev_q, prev_d;
    logic            end_q, end_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;
    logic            in_ready_q, in_ready_d;
    logic            start_q, start_d;
    logic            accept;
    logic            addr_ok;

    assign accept  = bus.in_valid && in_ready_q;
    // addr_q is one bit wider so it can sit at MAX_ADDR+1 and still compare correctly
    assign addr_ok = (addr_q <= {1'b0, MAX_ADDR});

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        prev_d       = prev_q;
        end_d        = end_q;
        count_d      = count_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_LOW: begin
                if (accept) begin
                    wdata_d[7:0] = bus.in_data;
                    prev_d       = bus.in_data;
                    if (prev_q == 8'hFF && bus.in_data == 8'hD9) begin
                        wdata_d[15:8] = PAD_BYTE;
                        end_d         = 1'b1;
                        state_d       = S_WRITE;
                    end else begin
                        end_d   = 1'b0;
                        state_d = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (accept) begin
                    wdata_d[15:8] = bus.in_data;
                    prev_d        = bus.in_data;
                    end_d         = (prev_q == 8'hFF && bus.in_data == 8'hD9);
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!addr_ok) begin
                    overflow_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.sram_ready) begin
                    count_d = count_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = end_q ? S_DONE : S_LOW;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOW;
            end
        endcase

        // Handshake and start strobe are registered from the next state so they stay glitch-free
        in_ready_d   = (state_d == S_LOW) || (state_d == S_HIGH);
        start_d      = !((state_d == S_WRITE) && addr_ok);
        frame_done_d = frame_done_q || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOW;
            addr_q       <= '0;
            wdata_q      <= '0;
            prev_q       <= '0;
            end_q        <= 1'b0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            start_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            prev_q       <= prev_d;
            end_q        <= end_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            in_ready_q   <= in_ready_d;
            start_q      <= start_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.sram_addr  = addr_q[ADDR_W-1:0];
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_rw    = 1'b0;
    assign bus.sram_start = start_q;
    assign word_count     = count_q;
    assign frame_done     = frame_done_q;
    assign overflow       = overflow_q;
endmodule
